fetch_decode_queue: RTL and testbench

- Parametrised instruction buffer between fetch and decode, replacing the single stall-gated fetch/decode flop.
- Holds up to DEPTH fetched instructions, each with its PC+8, under a valid/ready handshake.
- Presents the head entry to decode with pre-extracted register and condition fields.
- Supports a synchronous flush for branch redirect, so fetch can run ahead while decode stalls.

---
 rtl/fetch_decode_queue.sv | 82 ++++++++
 tb/tb_fetch_decode_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular FIFO of
// {instr, pcplus8} with valid/ready handshakes, branch flush and decoded head fields.
module fetch_decode_queue #(
   parameter int WIDTH = 32,
   parameter int PCW   = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_instr,
   input  logic [PCW-1:0]             in_pcplus8,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_instr,
   output logic [PCW-1:0]             out_pcplus8,
   output logic [3:0]                 out_cond,
   output logic [3:0]                 out_rn,
   output logic [3:0]                 out_rd,
   output logic [3:0]                 out_rs,
   output logic [3:0]                 out_rm,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_instr [DEPTH];
   logic [PCW-1:0]   mem_pc    [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   // Both handshake flags come from the registered count only, so there is
   // no combinational path from out_ready to in_ready or from input to output.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; an empty queue masks whatever it holds.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_pc[wr_ptr]    <= in_pcplus8;
      end
   end

   assign out_instr   = out_valid ? mem_instr[rd_ptr] : '0;
   assign out_pcplus8 = out_valid ? mem_pc[rd_ptr]    : '0;

   assign out_cond = out_instr[31:28];
   assign out_rn   = out_instr[19:16];
   assign out_rd   = out_instr[15:12];
   assign out_rs   = out_instr[11:8];
   assign out_rm   = out_instr[3:0];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed and random steps against a queue-based model.
module tb_fetch_decode_queue;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pcplus8;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pcplus8;
   logic [3:0]  out_cond, out_rn, out_rd, out_rs, out_rm;
   logic [2:0]  count;

   int   errors = 0;
   int   checks = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   fetch_decode_queue #(.WIDTH(32), .PCW(32), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pcplus8(in_pcplus8),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pcplus8(out_pcplus8),
      .out_cond(out_cond), .out_rn(out_rn), .out_rd(out_rd),
      .out_rs(out_rs), .out_rm(out_rm), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's current contents.
   task automatic check_state(input string ph);
      logic [31:0] hi, hp;
      hi = (q.size() > 0) ? q[0].instr : 32'h0;
      hp = (q.size() > 0) ? q[0].pc    : 32'h0;
      chk({ph, " count"},     32'(count),     32'(q.size()));
      chk({ph, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({ph, " in_ready"},  32'(in_ready),  32'(q.size() < 4));
      chk({ph, " out_instr"}, out_instr,      hi);
      chk({ph, " out_pc"},    out_pcplus8,    hp);
      chk({ph, " fields"},
          {12'h0, out_cond, out_rn, out_rd, out_rs, out_rm},
          {12'h0, hi[31:28], hi[19:16], hi[15:12], hi[11:8], hi[3:0]});
   endtask

   // One clock: drive at the falling edge, check, clock, update the model.
   task automatic step(input string ph, input bit v, input bit r, input bit f,
                       input logic [31:0] ins, input logic [31:0] pc);
      bit   do_push, do_pop;
      ent_t e;
      in_valid = v; out_ready = r; flush = f; in_instr = ins; in_pcplus8 = pc;
      #1;
      check_state(ph);
      do_push = v && (q.size() < 4);
      do_pop  = r && (q.size() > 0);
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.instr = ins; e.pc = pc;
            q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] fill_i [4];
      logic [31:0] held_i, held_p;
      fill_i[0] = 32'hE0810002; fill_i[1] = 32'hE2433001;
      fill_i[2] = 32'hE5921000; fill_i[3] = 32'hEAFFFFFE;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pcplus8 = '0;
      #12;
      check_state("reset");
      @(negedge clk);
      reset = 1'b0;

      // Ordered fill to full, then full-boundary behaviour.
      for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, fill_i[i], 32'h108 + 32'(4*i));
      chk("full count", 32'(count), 32'd4);
      chk("full in_ready", 32'(in_ready), 32'd0);
      chk("head cond", 32'(out_cond), 32'hE);
      chk("head rn",   32'(out_rn),   32'd1);
      chk("head rd",   32'(out_rd),   32'd0);
      chk("head rm",   32'(out_rm),   32'd2);
      step("full_hold", 1, 0, 0, 32'hE1A00000, 32'h118);
      step("full_pop",  1, 1, 0, 32'hE1A00000, 32'h118);
      step("fifth",     1, 0, 0, 32'hE1A00000, 32'h118);
      for (int i = 0; i < 5; i++) step("drain", 0, 1, 0, 32'h0, 32'h0);
      check_state("empty");

      // Steady stream: count settles at 1, pointers wrap several times.
      for (int i = 0; i < 20; i++) step("stream", 1, 1, 0, $urandom, $urandom);
      step("stream_end", 0, 1, 0, 32'h0, 32'h0);

      // Stall hold with 2 entries.
      step("stall_fill", 1, 0, 0, 32'hE3A01005, 32'h200);
      step("stall_fill", 1, 0, 0, 32'hE0822003, 32'h204);
      held_i = out_instr; held_p = out_pcplus8;
      for (int i = 0; i < 10; i++) begin
         step("stall", 0, 0, 0, 32'h0, 32'h0);
         chk("stall instr", out_instr, held_i);
         chk("stall pc", out_pcplus8, held_p);
      end
      for (int i = 0; i < 2; i++) step("stall_drain", 0, 1, 0, 32'h0, 32'h0);

      // Flush with push and pop in the same cycle.
      for (int i = 0; i < 3; i++) step("fl_fill", 1, 0, 0, 32'hE1500000 + 32'(i), 32'h300 + 32'(4*i));
      step("flush", 1, 1, 1, 32'hDEADBEEF, 32'h3FC);
      chk("post_flush count", 32'(count), 32'd0);
      chk("post_flush valid", 32'(out_valid), 32'd0);
      step("after_flush", 1, 0, 0, 32'hE2811001, 32'h400);
      chk("after_flush head", out_instr, 32'hE2811001);
      step("after_flush", 0, 1, 0, 32'h0, 32'h0);

      // Random mix including occasional flushes.
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0), $urandom, $urandom);

      // Asynchronous reset mid-cycle with 3 entries queued.
      while (q.size() > 0) step("pre_rst", 0, 1, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, $urandom, $urandom);
      chk("pre_rst count", 32'(count), 32'd3);
      in_valid = 1'b1; in_instr = $urandom;
      #2 reset = 1'b1;
      #1;
      q.delete();
      check_state("async_rst");
      @(negedge clk);
      reset = 1'b0;
      step("rst_after", 1, 0, 0, 32'hE0800001, 32'h500);
      step("rst_after", 0, 1, 0, 32'h0, 32'h0);
      check_state("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
